// File: rtl/video_stream_monitor.sv
// Pixel-stream monitor on the tpclk domain: pixel coordinates, measured frame geometry,
// fps, per-frame checksum, sticky geometry errors and a lock indication for bring-up.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   WAIT_SOF | after reset; de ignored until the first start of frame
//   FRAME    | counting pixels/lines; each SOF closes the running frame

module video_stream_monitor #(
  parameter int DW          = 16,
  parameter int CW          = 16,
  parameter int IW          = 1280,
  parameter int IH          = 720,
  parameter int CLK_HZ      = 70000000,
  parameter int VS_POL      = 1,
  parameter int LOCK_FRAMES = 4
) (
  input  logic          tpclk,
  input  logic          rst,
  input  logic          vs,
  input  logic          de,
  input  logic [DW-1:0] data,
  input  logic          clr_err,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic [CW-1:0] meas_w,
  output logic [CW-1:0] meas_h,
  output logic [7:0]    fps,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   checksum,
  output logic          frame_done,
  output logic          err_w,
  output logic          err_h,
  output logic          locked
);

  localparam logic            VS_ACT   = (VS_POL != 0);
  localparam int              WIN_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CLK_HZ - 1);
  localparam logic [CW-1:0]   CNT_MAX  = '1;
  localparam logic [CW-1:0]   IW_C     = CW'(IW);
  localparam logic [CW-1:0]   IH_C     = CW'(IH);
  localparam int              LW       = (LOCK_FRAMES > 0) ? $clog2(LOCK_FRAMES + 1) : 1;
  localparam logic [LW-1:0]   LOCK_C   = LW'(LOCK_FRAMES);

  typedef enum logic {WAIT_SOF, FRAME} state_t;

  state_t           state;
  logic             vs_r, vs_q, de_r, de_q;
  logic [DW-1:0]    d_r;
  logic [15:0]      d16;
  logic [15:0]      acc;
  logic             frame_bad;
  logic [LW-1:0]    good_cnt, good_nxt;
  logic [WIN_W-1:0] win_cnt;
  logic [7:0]       sof_cnt, sof_cnt_inc;
  logic             sof, eol;
  logic [CW-1:0]    hcnt_inc, vcnt_inc, vcnt_close;
  logic             line_bad, height_bad, frame_good;

  // Checksum is mod 2^16: wider pixels lose their upper bits, narrower ones are zero-extended.
  generate
    if (DW >= 16) begin : g_trunc
      assign d16 = d_r[15:0];
    end else begin : g_ext
      assign d16 = {{(16-DW){1'b0}}, d_r};
    end
  endgenerate

  assign sof         = (vs_r == VS_ACT) && (vs_q != VS_ACT);
  assign eol         = de_q && !de_r;
  assign hcnt_inc    = (hcnt == CNT_MAX) ? hcnt : hcnt + CW'(1);
  assign vcnt_inc    = (vcnt == CNT_MAX) ? vcnt : vcnt + CW'(1);
  assign sof_cnt_inc = (sof_cnt == 8'hFF) ? sof_cnt : sof_cnt + 8'd1;

  // A line ending in the same cycle as SOF still belongs to the closing frame.
  assign line_bad    = (state == FRAME) && eol && (hcnt != IW_C);
  assign vcnt_close  = eol ? vcnt_inc : vcnt;
  assign height_bad  = (vcnt_close != IH_C);
  assign frame_good  = !frame_bad && !line_bad && !height_bad;

  always_comb begin
    good_nxt = good_cnt;
    if (state == FRAME) begin
      if (sof) begin
        if (frame_good) good_nxt = (good_cnt == LOCK_C) ? good_cnt : good_cnt + LW'(1);
        else            good_nxt = '0;
      end else if (line_bad) begin
        good_nxt = '0;
      end
    end
  end

  always_ff @(posedge tpclk) begin
    if (rst) begin
      state      <= WAIT_SOF;
      vs_r       <= 1'b0;
      vs_q       <= 1'b0;
      de_r       <= 1'b0;
      de_q       <= 1'b0;
      d_r        <= '0;
      acc        <= '0;
      frame_bad  <= 1'b0;
      good_cnt   <= '0;
      win_cnt    <= WIN_LAST;
      sof_cnt    <= '0;
      hcnt       <= '0;
      vcnt       <= '0;
      meas_w     <= '0;
      meas_h     <= '0;
      fps        <= '0;
      frame_cnt  <= '0;
      checksum   <= '0;
      frame_done <= 1'b0;
      err_w      <= 1'b0;
      err_h      <= 1'b0;
      locked     <= 1'b0;
    end else begin
      vs_r       <= vs;
      vs_q       <= vs_r;
      de_r       <= de;
      de_q       <= de_r;
      d_r        <= data;
      frame_done <= 1'b0;
      good_cnt   <= good_nxt;
      locked     <= (good_nxt == LOCK_C);

      // fps window: an SOF on the terminal-count cycle belongs to the ending window.
      if (win_cnt == '0) begin
        win_cnt <= WIN_LAST;
        fps     <= sof ? sof_cnt_inc : sof_cnt;
        sof_cnt <= '0;
      end else begin
        win_cnt <= win_cnt - WIN_W'(1);
        if (sof) sof_cnt <= sof_cnt_inc;
      end

      // Error sets further down override this clear.
      if (clr_err) begin
        err_w <= 1'b0;
        err_h <= 1'b0;
      end

      case (state)
        WAIT_SOF: begin
          if (sof) begin
            state     <= FRAME;
            hcnt      <= '0;
            vcnt      <= '0;
            acc       <= '0;
            frame_bad <= 1'b0;
          end
        end
        FRAME: begin
          if (de_r) begin
            hcnt <= hcnt_inc;
            acc  <= acc + d16;
          end
          if (eol) begin
            meas_w <= hcnt;
            hcnt   <= '0;
            vcnt   <= vcnt_inc;
            if (line_bad) begin
              err_w     <= 1'b1;
              frame_bad <= 1'b1;
            end
          end
          // An open line at SOF is simply discarded with the counters.
          if (sof) begin
            meas_h     <= vcnt_close;
            checksum   <= acc;
            frame_cnt  <= frame_cnt + 16'd1;
            frame_done <= 1'b1;
            if (height_bad) err_h <= 1'b1;
            hcnt       <= '0;
            vcnt       <= '0;
            acc        <= '0;
            frame_bad  <= 1'b0;
          end
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

endmodule
